bit_serializer: RTL
===================

# bit_serializer

Upstream feeder for the serial sequence-detector FSMs. It accepts parallel words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per enabled clock on the serial line `s`, which the detector samples on the same clock. Back-to-back words stream with no gap bit, so a detector pattern can span a word boundary.

## Interface
- WIDTH, 8, word width in bits (≥2)
- MSB_FIRST, 1, 1: din[WIDTH-1] is sent first; 0: din[0] is sent first
- IDLE_BIT, 0, level driven on `s` when no word is being sent
- ck  input  1  clock; all state changes on the rising edge
- rs  input  1  reset, asynchronous, active-high; clears all state immediately
- en  input  1  bit strobe; the serial line advances only on edges where en=1
- din  input  WIDTH  parallel word
- din_valid  input  1  din is offered
- din_ready  output  1  holding register is empty; equals !hold_valid
- s  output  1  serial bit, registered
- s_valid  output  1  `s` carries a data bit, registered
- busy  output  1  state==SHIFT or hold_valid
- word_done  output  1  one-cycle pulse: the last bit of a word has just been retired

## Operation
- Internal state: state {IDLE, SHIFT}, shift register sr[WIDTH-1:0], bit index cnt[$clog2(WIDTH)-1:0], hold[WIDTH-1:0], hold_valid.
- Reset values: state=IDLE, sr=0, cnt=0, hold=0, hold_valid=0, s=IDLE_BIT, s_valid=0, word_done=0. This gives din_ready=1 and busy=0.
- Accept: on an edge with din_valid && din_ready, set hold<=din and hold_valid<=1. din_ready is 0 while hold_valid=1, so a new accept never coincides with an occupied hold.
- Load condition: en=1, hold_valid=1, and either state==IDLE, or state==SHIFT with cnt==WIDTH-1. On a load:
  - s <= first bit of hold; s_valid<=1
  - sr <= hold advanced by one bit position
  - cnt<=0; hold_valid<=0; state<=SHIFT
- Shift: state==SHIFT, en=1, cnt<WIDTH-1 → s <= next bit from sr; cnt<=cnt+1.
- Retire: state==SHIFT, en=1, cnt==WIDTH-1 → word_done<=1 for one cycle.
  - If hold_valid=1, the load happens on the same edge, giving a gapless stream.
  - Otherwise s<=IDLE_BIT, s_valid<=0, state<=IDLE.
- en=0: s, s_valid, sr, cnt and state hold their values. Accepts still occur. word_done is 0.
- Bit order is selected by MSB_FIRST only. It is fixed at elaboration.

## Timing
- A word accepted at edge E is loaded at the first edge ≥E+1 with en=1. With en tied high, its first bit is valid on s after E+1.
- With en high: one bit per cycle, WIDTH cycles per word. word_done asserts in the cycle after the last bit's display cycle ends, i.e. it is registered at the edge that retires that bit.
- Gapless streaming requires the next word to be accepted no later than the edge that starts the last bit of the current word.
- Throughput limit: one accept per word time. din_ready falls at the accept edge and rises at the load edge.
- rs asserted mid-word: all outputs go to their reset values asynchronously. Partially sent and held words are discarded. No word_done is produced.
- rs deasserted: the first accept can occur at the first rising edge after deassertion.

## Structure
- Shared header `ser_defs`: state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1, and the default WIDTH and IDLE_BIT.
- A single module is sufficient. Optionally factor the handshake/holding register into the sub-module `ser_hold_reg` (din, din_valid, din_ready, take → hold, hold_valid).

## Test plan
- Reset and idle: hold rs=1 for 2 cycles → s=0, s_valid=0, din_ready=1, busy=0, word_done=0. Release with din_valid=0 → outputs unchanged for 10 cycles.
- Single word, en=1, MSB_FIRST=1, din=8'hAC accepted at edge E → s = 1,0,1,0,1,1,0,0 after edges E+1..E+8, with s_valid=1. word_done pulses once after E+9. Then s=0, s_valid=0.
- Back-to-back: 8'hA9 then 8'hAC, the second offered immediately → 16 contiguous bits with s_valid never dropping. word_done pulses after bit 8 and after bit 16. A downstream 101011 detector fires at the expected cycle.
- en gating: en toggles 1,0,1,0 during a word → each bit is held on s for 2 cycles. The total word time doubles. din_ready behaviour is unchanged.
- Backpressure: hold full while shifting → din_ready=0. A din_valid held high is not accepted until the load edge, then is accepted the next cycle. No word is lost or duplicated.
- Reset mid-operation: assert rs after bit 3 of 8'hFF, with 8'h00 held in hold → s=0, s_valid=0, busy=0 at once. After release, a new word 8'h81 is sent intact as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared serializer definitions (ser_defs): FSM state encodings and default parameters.
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam logic        DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register behind a valid/ready handshake; emptied by 'take'.
module ser_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             ck,
  input  logic             rs,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             take,
  output logic             din_ready,
  output logic [WIDTH-1:0] hold,
  output logic             hold_valid
);

  assign din_ready = !hold_valid;

  // Accept needs an empty hold and take needs a full one, so they never collide.
  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (din_valid && !hold_valid) begin
      hold       <= din;
      hold_valid <= 1'b1;
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: buffers one word and streams bits gaplessly on enabled edges.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             s,
  output logic             s_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic             load;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign load = en && hold_valid && ((state == ST_IDLE) || (cnt == LAST));
  assign busy = (state == ST_SHIFT) || hold_valid;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .ck        (ck),
    .rs        (rs),
    .din       (din),
    .din_valid (din_valid),
    .take      (load),
    .din_ready (din_ready),
    .hold      (hold),
    .hold_valid(hold_valid)
  );

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      state     <= ST_IDLE;
      sr        <= '0;
      cnt       <= '0;
      s         <= IDLE_BIT;
      s_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (en) begin
        if (state == ST_SHIFT && cnt != LAST) begin
          s   <= out_bit(sr);
          sr  <= advance(sr);
          cnt <= cnt + 1'b1;
        end else begin
          // Retiring the last bit and loading the next word share one edge: no gap bit.
          if (state == ST_SHIFT) word_done <= 1'b1;
          if (hold_valid) begin
            s       <= out_bit(hold);
            s_valid <= 1'b1;
            sr      <= advance(hold);
            cnt     <= '0;
            state   <= ST_SHIFT;
          end else begin
            s       <= IDLE_BIT;
            s_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
